// File: rtl/felica_pkg.sv
// Shared types, constants and the serial CRC-16/CCITT step for the FeliCa deframer.
// Combinational only: no latency and no flow control.
package felica_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CRC  = 2'd3
    } state_e;

    localparam logic [15:0] SYNC_DEFAULT = 16'hB24D;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'h0000;

    // One MSB-first bit through the CRC register.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/felica_crc16.sv
// Bit-serial CRC-16/CCITT register; clr has priority over en.
// Updates one cycle after en; no backpressure.
module felica_crc16
    import felica_pkg::*;
(
    input  logic        ck_1356meg,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        d,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else if (clr) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc_step(crc_q, d);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/felica_deframer.sv
// NFC-F receive deframer: preamble+sync hunt, MSB-first byte assembly, length tracking, CRC check.
// Outputs are registered, one cycle after the completing bit_stb; no backpressure (bytes are strobed out).
module felica_deframer
    import felica_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_DEFAULT,
    parameter int          PRE_MIN   = 16
) (
    input  logic       ck_1356meg,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_stb,
    input  logic       sync_lost,
    output logic [7:0] byte_out,
    output logic       byte_stb,
    output logic       frame_start,
    output logic       frame_end,
    output logic       crc_ok,
    output logic       aborted,
    output logic       busy
);

    localparam logic [7:0] PRE_MIN_B = 8'(PRE_MIN);

    state_e      state_q, state_d;
    logic [14:0] sh_q, sh_d;            // the 16th sync bit is the incoming one
    logic [7:0]  zrun_q, zrun_d;
    // Per-bit flag "this 1 followed >= PRE_MIN zeros"; the flag 15 bits back
    // is the preamble qualification captured at the sync's first bit.
    logic [14:0] pre_ok_q, pre_ok_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [6:0]  shb_q, shb_d;
    logic [7:0]  remain_q, remain_d;
    logic        crc_byte_q, crc_byte_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_stb_q, byte_stb_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        crc_ok_q, crc_ok_d;
    logic        aborted_q, aborted_d;

    logic        crc_clr, crc_en;
    logic [15:0] crc;
    logic [7:0]  byte_nxt;
    logic [15:0] sh_nxt;

    felica_crc16 u_crc (
        .ck_1356meg (ck_1356meg),
        .reset      (reset),
        .clr        (crc_clr),
        .en         (crc_en),
        .d          (bit_in),
        .crc        (crc)
    );

    always_comb begin
        state_d       = state_q;
        sh_d          = sh_q;
        zrun_d        = zrun_q;
        pre_ok_d      = pre_ok_q;
        bcnt_d        = bcnt_q;
        shb_d         = shb_q;
        remain_d      = remain_q;
        crc_byte_d    = crc_byte_q;
        byte_out_d    = byte_out_q;
        byte_stb_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        crc_ok_d      = 1'b0;
        aborted_d     = 1'b0;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;
        byte_nxt      = {shb_q, bit_in};
        sh_nxt        = {sh_q, bit_in};

        if (state_q == ST_HUNT) begin
            if (sync_lost) begin
                sh_d     = '0;
                zrun_d   = '0;
                pre_ok_d = '0;
            end else if (bit_stb) begin
                sh_d     = sh_nxt[14:0];
                zrun_d   = bit_in ? 8'd0 : ((zrun_q == 8'hFF) ? zrun_q : zrun_q + 8'd1);
                pre_ok_d = {pre_ok_q[13:0], bit_in & (zrun_q >= PRE_MIN_B)};
                if (sh_nxt == SYNC_WORD && pre_ok_q[14]) begin
                    frame_start_d = 1'b1;
                    crc_clr       = 1'b1;
                    bcnt_d        = 3'd0;
                    sh_d          = '0;
                    zrun_d        = '0;
                    pre_ok_d      = '0;
                    state_d       = ST_LEN;
                end
            end
        end else if (sync_lost) begin
            frame_end_d = 1'b1;
            aborted_d   = 1'b1;
            bcnt_d      = 3'd0;
            crc_byte_d  = 1'b0;
            state_d     = ST_HUNT;
        end else if (bit_stb) begin
            crc_en = 1'b1;
            shb_d  = byte_nxt[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
                byte_stb_d = 1'b1;
                byte_out_d = byte_nxt;
                case (state_q)
                    ST_LEN: begin
                        if (byte_nxt == 8'd0) begin
                            frame_end_d = 1'b1;
                            aborted_d   = 1'b1;
                            state_d     = ST_HUNT;
                        end else begin
                            remain_d   = byte_nxt - 8'd1;
                            crc_byte_d = 1'b0;
                            state_d    = (byte_nxt == 8'd1) ? ST_CRC : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        remain_d = remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            crc_byte_d = 1'b0;
                            state_d    = ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        if (!crc_byte_q) begin
                            crc_byte_d = 1'b1;
                        end else begin
                            frame_end_d = 1'b1;
                            crc_ok_d    = (crc_step(crc, bit_in) == 16'h0000);
                            crc_byte_d  = 1'b0;
                            state_d     = ST_HUNT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            sh_q          <= '0;
            zrun_q        <= '0;
            pre_ok_q      <= '0;
            bcnt_q        <= '0;
            shb_q         <= '0;
            remain_q      <= '0;
            crc_byte_q    <= 1'b0;
            byte_out_q    <= 8'h00;
            byte_stb_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            crc_ok_q      <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            zrun_q        <= zrun_d;
            pre_ok_q      <= pre_ok_d;
            bcnt_q        <= bcnt_d;
            shb_q         <= shb_d;
            remain_q      <= remain_d;
            crc_byte_q    <= crc_byte_d;
            byte_out_q    <= byte_out_d;
            byte_stb_q    <= byte_stb_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            crc_ok_q      <= crc_ok_d;
            aborted_q     <= aborted_d;
        end
    end

    assign byte_out    = byte_out_q;
    assign byte_stb    = byte_stb_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign crc_ok      = crc_ok_q;
    assign aborted     = aborted_q;
    assign busy        = (state_q != ST_HUNT) || frame_end_q;

endmodule
